alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Two-requester round-robin front end for one shared 8-bit ALU.
//            The winner's opcode and operands are latched and driven to the
//            ALU for one cycle (ISSUE). The ALU result, zero flag and an
//            illegal-opcode flag are then captured into that requester's
//            result registers, and a done pulse follows (DONE).
// Ports    : clk, rst_n               clock, synchronous active-low reset
//            req0/op0/a0/b0           requester 0 request, opcode, operands
//            req1/op1/a1/b1           requester 1 request, opcode, operands
//            gnt0/gnt1                one-cycle grant pulse (ISSUE cycle)
//            done0/done1              one-cycle completion pulse (DONE cycle)
//            res0/res1, zf0/zf1,
//            err0/err1                held result, zero flag, illegal flag
//            alu_control,
//            alu_input0/alu_input1    opcode/operands to the shared ALU
//            alu_output, alu_zero     combinational ALU result and zero flag
//            busy                     high whenever the FSM is not idle
// Revision : 1.0  initial release
// ============================================================================
module alu_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [2:0] op0,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic       req1,
    input  logic [2:0] op1,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] res0,
    output logic [7:0] res1,
    output logic       zf0,
    output logic       zf1,
    output logic       err0,
    output logic       err1,
    output logic [2:0] alu_control,
    output logic [7:0] alu_input0,
    output logic [7:0] alu_input1,
    input  logic [7:0] alu_output,
    input  logic       alu_zero,
    output logic       busy
);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_ISSUE      = 2'd1;
    localparam logic [1:0] c_DONE       = 2'd2;
    localparam logic [2:0] c_OP_ILLEGAL = 3'b101;

    logic [1:0] r_state;
    logic       r_win;      // owner of the operation in flight (1 = requester 1)
    logic       r_ill;      // operation in flight carries the illegal opcode
    logic       r_last;     // requester granted most recently
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_done0;
    logic       r_done1;
    logic [7:0] r_res0;
    logic [7:0] r_res1;
    logic       r_zf0;
    logic       r_zf1;
    logic       r_err0;
    logic       r_err1;
    logic [2:0] r_alu_control;
    logic [7:0] r_alu_input0;
    logic [7:0] r_alu_input1;
    logic       r_busy;

    logic       w_any;
    logic       w_pick1;
    logic [2:0] w_op;
    logic [7:0] w_a;
    logic [7:0] w_b;
    logic       w_ill;

    // Requester 1 wins when it is alone, or on a tie when requester 0 was
    // the last one served.
    always_comb begin
        w_any   = req0 | req1;
        w_pick1 = req1 & (~req0 | ~r_last);
        w_op    = w_pick1 ? op1 : op0;
        w_a     = w_pick1 ? a1  : a0;
        w_b     = w_pick1 ? b1  : b0;
        w_ill   = (w_op == c_OP_ILLEGAL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_win         <= 1'b0;
            r_ill         <= 1'b0;
            r_last        <= 1'b1;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
            r_res0        <= 8'h00;
            r_res1        <= 8'h00;
            r_zf0         <= 1'b0;
            r_zf1         <= 1'b0;
            r_err0        <= 1'b0;
            r_err1        <= 1'b0;
            r_alu_control <= 3'b000;
            r_alu_input0  <= 8'h00;
            r_alu_input1  <= 8'h00;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_state <= c_ISSUE;
                        r_win   <= w_pick1;
                        r_last  <= w_pick1;
                        r_ill   <= w_ill;
                        r_gnt0  <= ~w_pick1;
                        r_gnt1  <= w_pick1;
                        r_busy  <= 1'b1;
                        // An illegal opcode never reaches the ALU: the bus
                        // stays quiet and the result is forced at capture.
                        r_alu_control <= w_ill ? 3'b000 : w_op;
                        r_alu_input0  <= w_ill ? 8'h00  : w_a;
                        r_alu_input1  <= w_ill ? 8'h00  : w_b;
                    end
                end
                c_ISSUE: begin
                    r_state       <= c_DONE;
                    r_gnt0        <= 1'b0;
                    r_gnt1        <= 1'b0;
                    r_alu_control <= 3'b000;
                    r_alu_input0  <= 8'h00;
                    r_alu_input1  <= 8'h00;
                    if (r_win) begin
                        r_res1  <= r_ill ? 8'h00 : alu_output;
                        r_zf1   <= ~r_ill & alu_zero;
                        r_err1  <= r_ill;
                        r_done1 <= 1'b1;
                    end else begin
                        r_res0  <= r_ill ? 8'h00 : alu_output;
                        r_zf0   <= ~r_ill & alu_zero;
                        r_err0  <= r_ill;
                        r_done0 <= 1'b1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state       <= c_IDLE;
                    r_gnt0        <= 1'b0;
                    r_gnt1        <= 1'b0;
                    r_done0       <= 1'b0;
                    r_done1       <= 1'b0;
                    r_alu_control <= 3'b000;
                    r_alu_input0  <= 8'h00;
                    r_alu_input1  <= 8'h00;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0        = r_gnt0;
    assign gnt1        = r_gnt1;
    assign done0       = r_done0;
    assign done1       = r_done1;
    assign res0        = r_res0;
    assign res1        = r_res1;
    assign zf0         = r_zf0;
    assign zf1         = r_zf1;
    assign err0        = r_err0;
    assign err1        = r_err1;
    assign alu_control = r_alu_control;
    assign alu_input0  = r_alu_input0;
    assign alu_input1  = r_alu_input1;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter. Provides the shared ALU,
//            a transaction-level reference model that schedules expected
//            grant/done/result events by edge number, a per-cycle compare
//            process, directed scenarios with literal expectations and a
//            randomized phase.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0, req1;
    logic [2:0] op0, op1;
    logic [7:0] a0, b0, a1, b1;
    logic       gnt0, gnt1, done0, done1;
    logic [7:0] res0, res1;
    logic       zf0, zf1, err0, err1;
    logic [2:0] alu_control;
    logic [7:0] alu_input0, alu_input1;
    logic [7:0] alu_output;
    logic       alu_zero;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

    alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .op0        (op0),
        .a0         (a0),
        .b0         (b0),
        .req1       (req1),
        .op1        (op1),
        .a1         (a1),
        .b1         (b1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .done0      (done0),
        .done1      (done1),
        .res0       (res0),
        .res1       (res1),
        .zf0        (zf0),
        .zf1        (zf1),
        .err0       (err0),
        .err1       (err1),
        .alu_control(alu_control),
        .alu_input0 (alu_input0),
        .alu_input1 (alu_input1),
        .alu_output (alu_output),
        .alu_zero   (alu_zero),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared ALU (shifts move by one place).
    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        case (op)
            3'b000:  return a;
            3'b001:  return a + b;
            3'b010:  return a & b;
            3'b011:  return ~a;
            3'b100:  return ~(a | b);
            3'b110:  return a << 1;
            3'b111:  return a >> 1;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_output = alu_fn(alu_control, alu_input0, alu_input1);
    assign alu_zero   = (alu_output == 8'h00);

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %b required %b at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: on each edge, decide whether a request is accepted
    // (only once the previous operation's three-cycle slot has elapsed),
    // compute its result up front, and derive the outputs for the cycle
    // that follows from the edge number relative to the grant edge.
    // ------------------------------------------------------------------
    int         edge_cnt  = 0;
    int         next_free = 0;
    int         t_g       = 0;
    bit         t_valid   = 0;
    bit         t_w       = 0;
    bit         last      = 1;
    bit         mdl_ok    = 0;
    logic [7:0] t_res, t_in0, t_in1;
    logic [2:0] t_ctl;
    bit         t_zf, t_err;
    logic [7:0] m_res [2];
    bit         m_zf  [2];
    bit         m_err [2];
    bit         e_gnt [2];
    bit         e_done[2];
    logic [2:0] e_ctl;
    logic [7:0] e_in0, e_in1;
    bit         e_busy;

    initial begin
        forever begin
            bit         w;
            bit         is_issue, is_done;
            logic [2:0] op;
            logic [7:0] a, b;
            @(posedge clk);
            edge_cnt++;
            if (!rst_n) begin
                t_valid   = 0;
                last      = 1;
                next_free = edge_cnt + 1;
                for (int i = 0; i < 2; i++) begin
                    m_res[i] = 8'h00;
                    m_zf[i]  = 0;
                    m_err[i] = 0;
                end
                mdl_ok = 1;
            end else begin
                if (t_valid && edge_cnt == t_g + 1) begin
                    m_res[t_w] = t_res;
                    m_zf[t_w]  = t_zf;
                    m_err[t_w] = t_err;
                end
                if (edge_cnt >= next_free && (req0 || req1)) begin
                    if (req0 && req1) w = ~last;
                    else              w = req1;
                    op = w ? op1 : op0;
                    a  = w ? a1  : a0;
                    b  = w ? b1  : b0;
                    t_valid   = 1;
                    t_g       = edge_cnt;
                    t_w       = w;
                    last      = w;
                    next_free = edge_cnt + 3;
                    if (op == 3'b101) begin
                        t_res = 8'h00; t_zf = 0; t_err = 1;
                        t_ctl = 3'b000; t_in0 = 8'h00; t_in1 = 8'h00;
                    end else begin
                        t_res = alu_fn(op, a, b); t_zf = (t_res == 8'h00); t_err = 0;
                        t_ctl = op; t_in0 = a; t_in1 = b;
                    end
                end
            end
            is_issue  = t_valid && (edge_cnt == t_g);
            is_done   = t_valid && (edge_cnt == t_g + 1);
            e_gnt[0]  = is_issue && !t_w;
            e_gnt[1]  = is_issue && t_w;
            e_done[0] = is_done && !t_w;
            e_done[1] = is_done && t_w;
            e_ctl     = is_issue ? t_ctl : 3'b000;
            e_in0     = is_issue ? t_in0 : 8'h00;
            e_in1     = is_issue ? t_in1 : 8'h00;
            e_busy    = is_issue || is_done;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mdl_ok) begin
                chk1("gnt0",  gnt0,  e_gnt[0]);
                chk1("gnt1",  gnt1,  e_gnt[1]);
                chk1("done0", done0, e_done[0]);
                chk1("done1", done1, e_done[1]);
                chk8("res0",  res0,  m_res[0]);
                chk8("res1",  res1,  m_res[1]);
                chk1("zf0",   zf0,   m_zf[0]);
                chk1("zf1",   zf1,   m_zf[1]);
                chk1("err0",  err0,  m_err[0]);
                chk1("err1",  err1,  m_err[1]);
                chk8("alu_control", {5'd0, alu_control}, {5'd0, e_ctl});
                chk8("alu_input0",  alu_input0, e_in0);
                chk8("alu_input1",  alu_input1, e_in1);
                chk1("busy",  busy,  e_busy);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_gnt(input int which, input int maxc);
        bit seen = 0;
        for (int k = 0; k < maxc && !seen; k++) begin
            @(negedge clk);
            if ((which == 0) ? gnt0 : gnt1) seen = 1;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL wait_gnt%0d: actual no grant required grant within %0d cycles",
                     which, maxc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        tick(2);
        chk1("rst_gnt0", gnt0, 1'b0);
        chk1("rst_gnt1", gnt1, 1'b0);
        chk1("rst_done0", done0, 1'b0);
        chk1("rst_done1", done1, 1'b0);
        chk8("rst_res0", res0, 8'h00);
        chk8("rst_res1", res1, 8'h00);
        chk1("rst_err0", err0, 1'b0);
        chk1("rst_zf1", zf1, 1'b0);
        chk8("rst_ctl", {5'd0, alu_control}, 8'h00);
        chk8("rst_in0", alu_input0, 8'h00);
        chk1("rst_busy", busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; op0 = 3'b000; a0 = 8'h00; b0 = 8'h00;
        req1 = 1'b0; op1 = 3'b000; a1 = 8'h00; b1 = 8'h00;

        // Single add, overflow into bit 7.
        do_reset();
        rst_n = 1'b1; req0 = 1'b1; op0 = 3'b001; a0 = 8'h7F; b0 = 8'h01;
        tick(1);
        chk1("single_gnt0", gnt0, 1'b1);
        chk1("single_busy1", busy, 1'b1);
        chk8("single_ctl", {5'd0, alu_control}, 8'h01);
        chk8("single_in0", alu_input0, 8'h7F);
        req0 = 1'b0; a0 = 8'h00;
        tick(1);
        chk1("single_done0", done0, 1'b1);
        chk8("single_res0", res0, 8'h80);
        chk1("single_zf0", zf0, 1'b0);
        chk1("single_err0", err0, 1'b0);
        chk1("single_busy2", busy, 1'b1);
        tick(1);
        chk1("single_busy3", busy, 1'b0);

        // Tie after reset, then alternate.
        do_reset();
        rst_n = 1'b1; req0 = 1'b1; req1 = 1'b1;
        op0 = 3'b000; a0 = 8'h11; op1 = 3'b001; a1 = 8'h02; b1 = 8'h03;
        tick(1);
        chk1("tie_gnt0", gnt0, 1'b1);
        chk1("tie_gnt1_lo", gnt1, 1'b0);
        req0 = 1'b0;
        tick(1);
        chk8("tie_res0", res0, 8'h11);
        wait_gnt(1, 4);
        req1 = 1'b0;
        tick(1);
        chk1("tie_done1", done1, 1'b1);
        chk8("tie_res1", res1, 8'h05);
        req0 = 1'b1; req1 = 1'b1;
        op0 = 3'b011; a0 = 8'h5A; op1 = 3'b100; a1 = 8'h01; b1 = 8'h02;
        wait_gnt(0, 4);
        chk1("tie2_gnt1_lo", gnt1, 1'b0);
        req0 = 1'b0;
        tick(1);
        chk8("tie2_res0", res0, 8'hA5);
        wait_gnt(1, 4);
        req1 = 1'b0;
        tick(1);
        chk8("tie2_res1", res1, 8'hFC);

        // Zero flag on requester 1, requester 0 untouched.
        req1 = 1'b1; op1 = 3'b010; a1 = 8'hF0; b1 = 8'h0F;
        wait_gnt(1, 4);
        req1 = 1'b0;
        tick(1);
        chk1("zero_done1", done1, 1'b1);
        chk8("zero_res1", res1, 8'h00);
        chk1("zero_zf1", zf1, 1'b1);
        chk8("zero_res0_kept", res0, 8'hA5);
        chk1("zero_zf0_kept", zf0, 1'b0);
        chk1("zero_err0_kept", err0, 1'b0);

        // Illegal opcode.
        req0 = 1'b1; op0 = 3'b101; a0 = 8'h33; b0 = 8'h44;
        wait_gnt(0, 4);
        chk8("ill_ctl", {5'd0, alu_control}, 8'h00);
        chk8("ill_in0", alu_input0, 8'h00);
        req0 = 1'b0;
        tick(1);
        chk1("ill_done0", done0, 1'b1);
        chk8("ill_res0", res0, 8'h00);
        chk1("ill_zf0", zf0, 1'b0);
        chk1("ill_err0", err0, 1'b1);

        // Shift right, operands disturbed after the grant, result held.
        req1 = 1'b1; op1 = 3'b111; a1 = 8'h81; b1 = 8'h03;
        wait_gnt(1, 4);
        chk8("srl_in0", alu_input0, 8'h81);
        req1 = 1'b0; a1 = 8'hFF; op1 = 3'b000;
        tick(1);
        chk8("srl_res1", res1, 8'h40);
        req0 = 1'b1; op0 = 3'b001; a0 = 8'h01; b0 = 8'h01;
        wait_gnt(0, 4);
        req0 = 1'b0;
        tick(1);
        chk8("hold_res0", res0, 8'h02);
        chk1("hold_err0", err0, 1'b0);
        chk8("hold_res1", res1, 8'h40);

        // Reset during ISSUE aborts; pending requester 1 served on release.
        req0 = 1'b1; op0 = 3'b001; a0 = 8'h10; b0 = 8'h10;
        wait_gnt(0, 4);
        rst_n = 1'b0; req0 = 1'b0;
        req1 = 1'b1; op1 = 3'b001; a1 = 8'h03; b1 = 8'h04;
        tick(1);
        chk1("abort_done0", done0, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk8("abort_res0", res0, 8'h00);
        chk8("abort_res1", res1, 8'h00);
        chk1("abort_err0", err0, 1'b0);
        rst_n = 1'b1;
        tick(1);
        chk1("abort_gnt1", gnt1, 1'b1);
        req1 = 1'b0;
        tick(1);
        chk1("abort_done1", done1, 1'b1);
        chk8("abort_res1_new", res1, 8'h07);

        // Randomized traffic, occasional resets, held and disturbed requests.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 99) != 0);
            if (gnt0) begin
                op0 = 3'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
                req0 = ($urandom_range(0, 3) == 0);
            end else if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1'b1; op0 = 3'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
            end
            if (gnt1) begin
                op1 = 3'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
                req1 = ($urandom_range(0, 3) == 0);
            end else if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1'b1; op1 = 3'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
            end
        end
        rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
